// File: rtl/logic_gates_seq.sv
// Bitwise gate unit: registered result of x0 op x1. The operation steps through
// AND..XNOR on a debounced button press or on a periodic auto-advance tick.
module logic_gates_seq #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int AUTO_CYCLES     = 12000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             btn,
    input  logic             auto_en,
    output logic [WIDTH-1:0] z0,
    output logic [2:0]       op,
    output logic [5:0]       leds
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int AT_W = $clog2(AUTO_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [DB_W-1:0]  r_db_cnt;
    logic [AT_W-1:0]  r_timer;
    op_e              r_op;
    op_e              w_op_next;
    logic [WIDTH-1:0] r_z0;
    logic [WIDTH-1:0] w_f;
    logic             w_db_diff;
    logic             w_db_flip;
    logic             w_btn_req;
    logic             w_auto_req;
    logic             w_adv;

    // The counter only ever reaches DEBOUNCE_CYCLES-1; the next differing sample flips db.
    assign w_db_diff  = r_s2 ^ r_db;
    assign w_db_flip  = w_db_diff && (r_db_cnt == DB_LAST);
    assign w_btn_req  = w_db_flip && !r_db;
    assign w_auto_req = auto_en && (r_timer == AT_LAST);
    assign w_adv      = w_btn_req || w_auto_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            if (w_db_flip) begin
                r_db     <= ~r_db;
                r_db_cnt <= '0;
            end else if (w_db_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !auto_en || w_auto_req) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_op_next = r_op;
        if (w_adv) begin
            case (r_op)
                OP_AND:  w_op_next = OP_OR;
                OP_OR:   w_op_next = OP_XOR;
                OP_XOR:  w_op_next = OP_NAND;
                OP_NAND: w_op_next = OP_NOR;
                OP_NOR:  w_op_next = OP_XNOR;
                default: w_op_next = OP_AND;
            endcase
        end
    end

    always_comb begin
        w_f = '0;
        case (r_op)
            OP_AND:  w_f = x0 & x1;
            OP_OR:   w_f = x0 | x1;
            OP_XOR:  w_f = x0 ^ x1;
            OP_NAND: w_f = ~(x0 & x1);
            OP_NOR:  w_f = ~(x0 | x1);
            OP_XNOR: w_f = ~(x0 ^ x1);
            default: w_f = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_AND;
            r_z0 <= '0;
        end else begin
            r_op <= w_op_next;
            r_z0 <= w_f;
        end
    end

    assign op   = r_op;
    assign z0   = r_z0;
    assign leds = 6'b000001 << r_op;

endmodule

// File: tb/tb_logic_gates_seq.sv
// Directed bench for logic_gates_seq: expected z0 values queued as operands are
// driven and compared when the registered result appears; op/leds follow a bench model.
module tb_logic_gates_seq;

    localparam int W  = 4;
    localparam int DB = 4;
    localparam int AC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic         auto_en;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] z0;
    logic [2:0]   op;
    logic [5:0]   leds;

    int n_checks = 0;
    int n_err    = 0;
    int exp_op   = 0;
    logic [W-1:0] sb_q[$];

    logic_gates_seq #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_CYCLES(AC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x0(x0),
        .x1(x1),
        .btn(btn),
        .auto_en(auto_en),
        .z0(z0),
        .op(op),
        .leds(leds)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] gate(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock edge: queue the result expected from the current operands and modelled op,
    // then compare z0 and the post-edge op/leds.
    task automatic edge_chk(input string tag, input bit adv);
        logic [5:0]   e_leds;
        logic [W-1:0] e_z0;
        sb_q.push_back(gate(exp_op, x0, x1));
        tick();
        if (adv) exp_op = (exp_op + 1) % 6;
        e_z0   = sb_q.pop_front();
        e_leds = 6'b000001 << exp_op;
        check({tag, "_z0"},   32'(z0),   32'(e_z0));
        check({tag, "_op"},   32'(op),   32'(exp_op));
        check({tag, "_leds"}, 32'(leds), 32'(e_leds));
    endtask

    task automatic do_reset(input bit b);
        rst     = 1'b1;
        btn     = b;
        auto_en = 1'b0;
        x0      = 4'b1100;
        x1      = 4'b1010;
        tick();
        tick();
        check("rst_op",   32'(op),   32'd0);
        check("rst_leds", 32'(leds), 32'b000001);
        check("rst_z0",   32'(z0),   32'd0);
        rst    = 1'b0;
        exp_op = 0;
        sb_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        btn     = 1'b0;
        auto_en = 1'b0;
        x0      = '0;
        x1      = '0;

        // Gate truth table via auto-advance, then random operands
        do_reset(1'b0);
        auto_en = 1'b1;
        for (int e = 0; e < 48; e++) edge_chk("gate", (e % 8) == 7);
        for (int e = 48; e < 96; e++) begin
            x0 = 4'($urandom);
            x1 = 4'($urandom);
            edge_chk("rand", (e % 8) == 7);
        end

        // Button held through reset release: single advance at edge 5
        do_reset(1'b1);
        x0 = 4'b1100;
        x1 = 4'b1010;
        for (int e = 0; e < 14; e++) begin
            btn = (e < 8);
            edge_chk("deb", e == 5);
        end
        for (int e = 0; e < 12; e++) begin
            btn = (e >= 1 && e < 4);
            edge_chk("pulse3", 1'b0);
        end
        for (int e = 0; e < 14; e++) begin
            btn = (e >= 1 && e < 5);
            edge_chk("pulse4", e == 6);
        end

        // Six presses wrap op back to 0
        do_reset(1'b0);
        for (int e = 0; e < 84; e++) begin
            btn = (e % 14) < 7;
            edge_chk("wrap", (e % 14) == 5);
        end

        // Auto timer restart after auto_en drop
        do_reset(1'b0);
        for (int e = 0; e < 28; e++) begin
            auto_en = !(e == 10 || e == 11);
            edge_chk("auto", e == 7 || e == 19 || e == 27);
        end

        // Button acceptance coinciding with timer terminal
        do_reset(1'b0);
        for (int e = 0; e < 18; e++) begin
            auto_en = 1'b1;
            btn     = (e >= 2);
            edge_chk("coll", e == 7 || e == 15);
        end

        // Reset mid-operation with op=3 and debounce counter at 2
        do_reset(1'b0);
        for (int e = 0; e < 42; e++) begin
            btn = (e % 14) < 7;
            edge_chk("pre", (e % 14) == 5);
        end
        for (int e = 0; e < 4; e++) begin
            btn = 1'b1;
            edge_chk("arm", 1'b0);
        end
        rst = 1'b1;
        btn = 1'b0;
        tick();
        check("mid_rst_op",   32'(op),   32'd0);
        check("mid_rst_z0",   32'(z0),   32'd0);
        check("mid_rst_leds", 32'(leds), 32'b000001);
        rst    = 1'b0;
        exp_op = 0;
        sb_q.delete();
        for (int e = 0; e < 12; e++) edge_chk("post", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_gates_seq.md
LOGIC_GATES_SEQ -- requirements
Module: logic_gates_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, giving the number of consecutive stable samples needed to accept a button level change (legal range 2 or more).
REQ-003 The block SHALL have parameter AUTO_CYCLES, default 12000000, giving the auto-advance period in clocks (legal range 2 or more).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port x0, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port x1, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing "next operation" button.
REQ-009 The block SHALL have port auto_en, input, 1 bit: when 1, the operation advances automatically every AUTO_CYCLES clocks.
REQ-010 The block SHALL have port z0, output, WIDTH bits: registered bitwise result.
REQ-011 The block SHALL have port op, output, 3 bits: current operation code.
REQ-012 The block SHALL have port leds, output, 6 bits: one-hot indicator of the current operation, with leds[op] = 1.

Function
REQ-013 Operation codes SHALL be 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, applied bitwise across all WIDTH bits; codes 6 and 7 SHALL never be reached.
REQ-014 Each clock, z0 SHALL load f(op, x0, x1) using the op register value before that edge, giving 1-cycle latency from x0/x1/op to z0.
REQ-015 leds SHALL be decoded combinationally from the op register, change in the same cycle as op, and always be exactly one-hot.
REQ-016 btn SHALL pass through a 2-flop synchroniser (s1, s2) before any other use.
REQ-017 Debounce: a counter SHALL increment on each cycle where s2 differs from the debounced level db, and clear on any cycle where they are equal.
REQ-018 When the DEBOUNCE_CYCLES-th consecutive differing sample is seen, db SHALL toggle and the counter SHALL clear on that same edge.
REQ-019 Only a db transition 0->1 SHALL request an advance; a 1->0 transition SHALL request nothing.
REQ-020 Latency: with btn held high and first sampled at edge k, op SHALL change at edge k+DEBOUNCE_CYCLES+1.
REQ-021 Any pulse on btn shorter than DEBOUNCE_CYCLES clocks after synchronisation SHALL cause no advance.
REQ-022 Auto timer: while auto_en=1 the timer SHALL increment each clock; at the edge where it equals AUTO_CYCLES-1 it SHALL request an advance and return to 0.
REQ-023 While auto_en=0 the timer SHALL be held at 0, so re-enabling always starts a full period.
REQ-024 An advance SHALL set op to op+1, wrapping 5 -> 0.
REQ-025 A button request and an auto request on the same edge SHALL advance op by exactly one, and the timer SHALL still return to 0.
REQ-026 An advance SHALL take effect on the same edge as the request that causes it.

Reset
REQ-027 When rst=1 at an edge: op SHALL be 0, leds SHALL be 6'b000001, and z0 SHALL be all zeros.
REQ-028 When rst=1 at an edge: s1, s2, db, the debounce counter and the auto timer SHALL all be 0.
REQ-029 Reset SHALL take priority over every other event on that edge.
REQ-030 If btn is held high through the release of reset, exactly one advance SHALL occur, DEBOUNCE_CYCLES+1 edges after the first post-reset edge.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, AUTO_CYCLES=8)
REQ-031 Gate truth: x0=4'b1100, x1=4'b1010, stepping op 0..5 -> z0 = 1000, 1110, 0110, 0111, 0001, 1001 one cycle after each op value.
REQ-032 Debounce: btn high from edge 0 -> op goes 0->1 at edge 5, leds=000010; a 3-cycle btn pulse -> op unchanged.
REQ-033 Wrap: six accepted presses from op=0 -> op sequence 1,2,3,4,5,0, with leds one-hot at every step.
REQ-034 Auto mode: auto_en=1 from edge 0 -> op increments at edges 7, 15, 23; dropping auto_en at edge 10 then raising it at edge 12 -> next advance at edge 19.
REQ-035 Collision: button acceptance and timer terminal on the same edge -> op +1 only, and the next auto advance comes 8 edges later.
REQ-036 Reset mid-operation: rst at edge 6 with op=3 and the debounce counter at 2 -> op=0, z0=0, leds=000001 at edge 6, and no spurious advance afterwards while btn=0.
